// File: rtl/multicycle_core_controller.sv
// -----------------------------------------------------------------------------
// multicycle_core_controller
//
// Sequencing FSM for the multi-cycle RV32I core. Fetches each instruction into
// the instruction register (which feeds the decoder), then walks it through
// DECODE / EXEC / optional MEM / WB. Write strobes are gated by state so that
// the decoder's per-instruction controls only reach the datapath in the cycle
// where they are meant to take effect.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   start                      pulse, leaves IDLE/HALT for FETCH
//   stop                       level, sampled in WB: halt after retiring
//   imem_req / imem_ack        instruction fetch handshake
//   imem_rdata                 fetched instruction word
//   ir                         instruction register, drives the decoder
//   dec_reg_wren               decoder: instruction writes rd
//   dec_ram_wren               decoder: instruction is a store
//   dec_reg_write_data_src     decoder: writeback comes from RAM (load)
//   dmem_req / dmem_ack        data memory handshake
//   ram_wren, reg_wren, pc_wren  gated write strobes
//   state                      current state (IDLE=0 .. HALT=6)
//   halted                     high while in HALT
//   err                        0 none, 1 illegal opcode, 2 memory timeout
//   cycle_count                cycles spent outside IDLE/HALT
//   instret_count              retired instructions
// -----------------------------------------------------------------------------
module multicycle_core_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          ir,
    input  logic                 dec_reg_wren,
    input  logic                 dec_ram_wren,
    input  logic                 dec_reg_write_data_src,
    output logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 ram_wren,
    output logic                 reg_wren,
    output logic                 pc_wren,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [1:0]           err,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Wait counter only has to reach TIMEOUT_CYCLES-1.
    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_SYSTEM = 7'h73;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17: legal_op = 1'b1;
            default:                    legal_op = 1'b0;
        endcase
    endfunction

    // Requests and strobes are pure decodes of the state register; the decoder
    // controls only pass through in the state that owns them, so ram_wren and
    // reg_wren can never overlap.
    assign imem_req = (state_q == S_FETCH);
    assign dmem_req = (state_q == S_MEM);
    assign ram_wren = (state_q == S_MEM) && dec_ram_wren;
    assign reg_wren = (state_q == S_WB)  && dec_reg_wren;
    assign pc_wren  = (state_q == S_WB);
    assign state    = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            ir            <= '0;
            err           <= ERR_NONE;
            halted        <= 1'b0;
            wait_q        <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_HALT)
                cycle_count <= cycle_count + CNT_WIDTH'(1);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end

                S_FETCH: begin
                    // An ack in the final allowed cycle still wins over the trap.
                    if (imem_ack) begin
                        ir      <= imem_rdata;
                        state_q <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                        err     <= ERR_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                S_DECODE: begin
                    if (legal_op(ir[6:0])) begin
                        state_q <= S_EXEC;
                    end else begin
                        // SYSTEM is the clean way to stop; anything else traps.
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                        err     <= (ir[6:0] == OP_SYSTEM) ? ERR_NONE : ERR_ILLEGAL;
                    end
                end

                S_EXEC: begin
                    if (dec_ram_wren || dec_reg_write_data_src) begin
                        state_q <= S_MEM;
                        wait_q  <= '0;
                    end else begin
                        state_q <= S_WB;
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        state_q <= S_WB;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                        err     <= ERR_TIMEOUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end

                S_WB: begin
                    instret_count <= instret_count + CNT_WIDTH'(1);
                    if (stop) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end

                S_HALT: begin
                    // Restart clears the error but keeps the counters.
                    if (start) begin
                        state_q <= S_FETCH;
                        halted  <= 1'b0;
                        err     <= ERR_NONE;
                        wait_q  <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule
